// File: rtl/sisc_mem_resp.sv
// Single-outstanding memory responder for the SISC load/store bus.
// Each request waits WAIT_CYCLES states, accesses a DEPTH-word array, then pulses ack.
module sisc_mem_resp #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ack;
  logic                r_err;
  logic                r_busy;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_in_range;
  logic [IDX_W-1:0]    w_idx;
  logic                w_mem_we;

  // Extra MSB lets DEPTH = 2^ADDR_W compare correctly.
  assign w_in_range = ({1'b0, r_addr} < DEPTH_L);
  assign w_idx      = r_addr[IDX_W-1:0];
  assign w_mem_we   = rst_f && (r_state == ST_ACCESS) && r_we && w_in_range;

  // Next-state decode
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next = ST_ACCESS;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // State, handshake outputs and request holding registers
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ack   <= (w_next == ST_RESP);
      r_busy  <= (w_next != ST_IDLE);
      r_err   <= (r_state == ST_ACCESS) && !w_in_range;
      if ((r_state == ST_IDLE) && req) begin
        r_we    <= we;
        r_addr  <= addr;
        r_wdata <= wdata;
        r_cnt   <= WAIT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Out-of-range reads return zero; writes leave rdata alone.
      if ((r_state == ST_ACCESS) && !r_we) begin
        r_rdata <= w_in_range ? r_mem[w_idx] : '0;
      end
    end
  end

  // Data array is not reset; reset still blocks a coinciding write.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign rdata = r_rdata;
  assign ack   = r_ack;
  assign err   = r_err;
  assign busy  = r_busy;

endmodule

// File: doc/sisc_mem_resp.md
# sisc_mem_resp

Memory responder for the SISC multicycle datapath: the slave end of the load/store bus driven by the control FSM during LOD, STR and SWP. It accepts one single-word read or write request at a time and applies a programmable number of wait states. It then completes the request with a one-cycle acknowledge pulse plus registered read data or an error flag. It holds a word-addressed data store of DEPTH entries and sits between the control unit and the register file write-back mux.

## Interface
- DATA_W, 32: data word width.
- ADDR_W, 16: request address width.
- DEPTH, 256: number of implemented words. Must satisfy DEPTH ≤ 2^ADDR_W.
- WAIT_CYCLES, 2: wait states inserted before each access. Legal range is 0..15.

- clk  in  1  system clock; all state changes on its rising edge.
- rst_f  in  1  reset, synchronous, active-low; sampled on rising clk.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; captured with req.
- addr  in  ADDR_W  word address; captured with req.
- wdata  in  DATA_W  write data; captured with req.
- rdata  out  DATA_W  registered read data; valid while ack=1, held until the next read completes.
- ack  out  1  one-cycle completion pulse.
- err  out  1  address-out-of-range flag; meaningful only while ack=1, otherwise 0.
- busy  out  1  high from request capture through the ack cycle.

## Operation
- FSM states:
  - IDLE → WAIT (req=1, WAIT_CYCLES>0) or ACCESS (req=1, WAIT_CYCLES=0).
  - WAIT → ACCESS when the wait counter is 0; otherwise decrement and stay in WAIT.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE unconditionally.
  - Illegal state encodings → IDLE.
- Capture: on the edge that leaves IDLE with req=1, latch we, addr and wdata into holding registers and load the wait counter with WAIT_CYCLES−1. Input changes after the capture edge have no effect on the request in flight.
- req while busy=1 (WAIT/ACCESS/RESP) is ignored, not queued.
- Access occurs on the edge leaving ACCESS:
  - Write, addr < DEPTH: mem[addr] ← wdata; rdata unchanged; err=0.
  - Read, addr < DEPTH: rdata ← mem[addr]; err=0.
  - addr ≥ DEPTH: no array write; rdata ← 0 for reads and unchanged for writes; err=1.
- ack=1 and busy=1 in RESP only for ack; err follows the rule above during RESP and is 0 in all other states.
- Read-after-write to the same address returns the newly written value.
- Array contents are not cleared by reset; registers and FSM state are.

## Timing
- Reset: when rst_f=0 at a rising edge, the next state is IDLE with ack=0, err=0, busy=0, rdata=0 and wait counter 0. This holds regardless of current state.
- Reset mid-operation: a request aborted before its ACCESS edge performs no write. A reset coinciding with the ACCESS edge also suppresses the write, because reset has priority.
- Request sampled at edge k:
  - busy=1 from edge k to edge k+WAIT_CYCLES+2.
  - ack=1 for exactly the cycle between edges k+WAIT_CYCLES+1 and k+WAIT_CYCLES+2.
- Latency with WAIT_CYCLES=0 is 1 cycle to ack; with the default WAIT_CYCLES=2 it is 3 cycles.
- Back-to-back: the earliest next capture edge is k+WAIT_CYCLES+3, leaving one IDLE cycle between transactions. A req held high continuously therefore produces one transaction every WAIT_CYCLES+3 cycles.
- busy and ack are registered outputs with no combinational path from req.

## Test plan
- Reset:
  - Drive rst_f=0 for 2 cycles with req=1 → ack=0, err=0, busy=0, rdata=0 throughout.
  - The first capture occurs on the first edge with rst_f=1 and req=1.
- Write then read, WAIT_CYCLES=2:
  - Write addr 0x0005, data 0xDEADBEEF, req sampled at edge 10 → busy on edges 10–14, ack only between edges 13 and 14, err=0.
  - Read addr 0x0005 → rdata=0xDEADBEEF during its ack cycle.
- Out of range:
  - Write addr 0x0100 (DEPTH=256) → ack with err=1; a read of addr 0x0000 returns its prior value.
  - Read addr 0xFFFF → ack with err=1 and rdata=0.
- Ignored requests and input stability:
  - Pulse req again during WAIT and during RESP → no extra ack.
  - Change addr/wdata after capture → the captured values are used.
  - Continuous req yields acks exactly 5 cycles apart.
- Reset abort: start a write to addr 3 (data 0x1234), assert rst_f=0 during WAIT → no ack; a later read of addr 3 returns the old value, not 0x1234.
- Zero-wait configuration, WAIT_CYCLES=0: read sampled at edge k → ack between edges k+1 and k+2; continuous req gives acks every 3 cycles.
